// File: rtl/mem_s2_arbiter.sv
// Two-requester arbiter for the s2 port of a shared on-chip RAM (read latency 1).
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN to make A always win ties.
module mem_s2_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic                a_gnt,
  output logic                a_done,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic                b_gnt,
  output logic                b_done,
  output logic [DATA_W-1:0]   b_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic                start;
  logic                win_b;
  logic                sel_b_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BE_W-1:0]     be_reg;
  logic                cs_reg, clken_reg, write_reg;
  logic                a_gnt_reg, b_gnt_reg, a_done_reg, b_done_reg;
  logic [DATA_W-1:0]   a_rdata_reg, b_rdata_reg;

  assign start = (state_reg == ST_IDLE) && (a_req || b_req);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win_b = b_req && !a_req;
`else
  // prio_b_reg set means B takes the next tie (A was served last)
  logic prio_b_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b_reg <= 1'b0;
    end else if (start) begin
      prio_b_reg <= !win_b;
    end
  end

  assign win_b = b_req && (!a_req || prio_b_reg);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_WAIT;
      ST_WAIT:   state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // All RAM-facing strobes are registered, decoded one cycle ahead from state_next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      sel_b_reg   <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      cs_reg      <= 1'b0;
      clken_reg   <= 1'b0;
      write_reg   <= 1'b0;
      a_gnt_reg   <= 1'b0;
      b_gnt_reg   <= 1'b0;
      a_done_reg  <= 1'b0;
      b_done_reg  <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cs_reg     <= 1'b0;
      write_reg  <= 1'b0;
      a_gnt_reg  <= 1'b0;
      b_gnt_reg  <= 1'b0;
      clken_reg  <= (state_next == ST_ACCESS) || (state_next == ST_WAIT);
      a_done_reg <= (state_reg == ST_WAIT) && !sel_b_reg;
      b_done_reg <= (state_reg == ST_WAIT) && sel_b_reg;
      if (start) begin
        sel_b_reg <= win_b;
        we_reg    <= win_b ? b_we    : a_we;
        addr_reg  <= win_b ? b_addr  : a_addr;
        wdata_reg <= win_b ? b_wdata : a_wdata;
        be_reg    <= win_b ? b_be    : a_be;
        cs_reg    <= 1'b1;
        write_reg <= win_b ? b_we : a_we;
        a_gnt_reg <= !win_b;
        b_gnt_reg <= win_b;
      end
      // RAM data for the ACCESS-cycle address is valid during WAIT
      if (state_reg == ST_WAIT && !we_reg) begin
        if (sel_b_reg) b_rdata_reg <= mem_readdata;
        else           a_rdata_reg <= mem_readdata;
      end
    end
  end

  assign a_gnt          = a_gnt_reg;
  assign b_gnt          = b_gnt_reg;
  assign a_done         = a_done_reg;
  assign b_done         = b_done_reg;
  assign a_rdata        = a_rdata_reg;
  assign b_rdata        = b_rdata_reg;
  assign mem_address    = addr_reg;
  assign mem_chipselect = cs_reg;
  assign mem_clken      = clken_reg;
  assign mem_write      = write_reg;
  assign mem_writedata  = wdata_reg;
  assign mem_byteenable = be_reg;
  assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_s2_arbiter.sv
// Randomized bench for mem_s2_arbiter: RAM model on s2, transaction-level
// reference (winner choice, shadow memory, expected rdata) inside the bench.
module tb_mem_s2_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BW = 4;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [BW-1:0] a_be, b_be;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_clken, mem_write;
  logic [DW-1:0] mem_writedata;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_readdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_s2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .busy(busy)
  );

  // RAM behind the s2 port, registered read
  logic [DW-1:0] ram [0:127];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int i = 0; i < BW; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      ram_q <= ram[mem_address];
    end
  end

  // Reference model state
  logic [DW-1:0] shadow [0:127];
  logic [DW-1:0] exp_rdata [0:1];
  bit            last_served_b;
  int            checks = 0;
  int            failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (p == 0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_be = be;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_be = be;
    end
  endtask

  // Drop the request and trash its fields; must not disturb an access in flight.
  task automatic scramble(input int p);
    if (p == 0) begin
      a_req = 1'b0; a_we = 1'($urandom); a_addr = 7'($urandom); a_wdata = $urandom; a_be = 4'($urandom);
    end else begin
      b_req = 1'b0; b_we = 1'($urandom); b_addr = 7'($urandom); b_wdata = $urandom; b_be = 4'($urandom);
    end
  endtask

  task automatic model_reset();
    last_served_b = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_gnt"}, {a_gnt, b_gnt}, 2'b00);
    check_val({tag, "_done"}, {a_done, b_done}, 2'b00);
    check_val({tag, "_strobes"}, {mem_chipselect, mem_clken, mem_write}, 3'b000);
    check_val({tag, "_a_rdata"}, a_rdata, 32'h0);
    check_val({tag, "_b_rdata"}, b_rdata, 32'h0);
  endtask

  // Called at a negedge with at least one req driven; returns at a negedge
  // with the DUT back in IDLE for the next sample.
  task automatic issue(input bit keep, output int w);
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    if (a_req && b_req) w = FIXED ? 0 : (last_served_b ? 0 : 1);
    else                w = a_req ? 0 : 1;
    we   = (w == 0) ? a_we    : b_we;
    addr = (w == 0) ? a_addr  : b_addr;
    d    = (w == 0) ? a_wdata : b_wdata;
    be   = (w == 0) ? a_be    : b_be;

    @(posedge clk); #1;
    check_val("acc_gnt", {a_gnt, b_gnt}, (w == 0) ? 2'b10 : 2'b01);
    check_val("acc_strobes", {mem_chipselect, mem_clken, mem_write, busy}, {3'b111 & {2'b11, we}, 1'b1});
    check_val("acc_addr", mem_address, addr);
    check_val("acc_wdata", mem_writedata, d);
    check_val("acc_be", mem_byteenable, be);
    last_served_b = (w == 1);
    if (we)
      for (int i = 0; i < BW; i++)
        if (be[i]) shadow[addr][8*i +: 8] = d[8*i +: 8];

    @(negedge clk);
    if (!keep) scramble(w);

    @(posedge clk); #1;
    check_val("wait_strobes", {mem_chipselect, mem_clken, mem_write}, 3'b010);
    check_val("wait_pulses", {a_gnt, b_gnt, a_done, b_done}, 4'b0000);

    @(posedge clk); #1;
    check_val("resp_done", {a_done, b_done}, (w == 0) ? 2'b10 : 2'b01);
    check_val("resp_strobes", {mem_chipselect, mem_clken, mem_write, busy}, 4'b0001);
    if (!we) exp_rdata[w] = shadow[addr];
    check_val("resp_a_rdata", a_rdata, exp_rdata[0]);
    check_val("resp_b_rdata", b_rdata, exp_rdata[1]);

    @(posedge clk); #1;
    check_val("idle_state", {busy, a_done, b_done, mem_clken}, 4'b0000);
    $display("txn port=%s we=%0d addr=%02h data=%08h be=%h", (w == 0) ? "A" : "B", we, addr, d, be);
    @(negedge clk);
  endtask

  int            w;
  logic [DW-1:0] v;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    ram_q = '0;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    check_val("rst_addr", mem_address, 7'h0);
    check_val("rst_wdata", mem_writedata, 32'h0);
    check_val("rst_be", mem_byteenable, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    // Contention from reset: both held for four accesses
    set_req(0, 1'b0, 7'h01, 32'h0, 4'h0);
    set_req(1, 1'b0, 7'h02, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, w);
      check_val("rr_order", w, FIXED ? 0 : (k % 2));
    end
    a_req = 1'b0; b_req = 1'b0;

    // Write then read back on A
    set_req(0, 1'b1, 7'h05, 32'hDEADBEEF, 4'hF); issue(1'b0, w);
    set_req(0, 1'b0, 7'h05, 32'h0, 4'h0);        issue(1'b0, w);
    check_val("wr_rd_a", a_rdata, 32'hDEADBEEF);

    // Partial byte-enable write, read by B
    set_req(0, 1'b1, 7'h10, 32'hFFFFFFFF, 4'hF); issue(1'b0, w);
    set_req(0, 1'b1, 7'h10, 32'h11223344, 4'h3); issue(1'b0, w);
    set_req(1, 1'b0, 7'h10, 32'h0, 4'h0);        issue(1'b0, w);
    check_val("be_merge", b_rdata, 32'hFFFF3344);

    // Zero byte-enable write leaves memory untouched
    set_req(1, 1'b0, 7'h7F, 32'h0, 4'h0);        issue(1'b0, w);
    v = b_rdata;
    set_req(0, 1'b1, 7'h7F, ~v, 4'h0);           issue(1'b0, w);
    set_req(1, 1'b0, 7'h7F, 32'h0, 4'h0);        issue(1'b0, w);
    check_val("be_zero", b_rdata, v);

    // Reset during WAIT of a read aborts it
    set_req(0, 1'b0, 7'h05, 32'h0, 4'h0);
    @(posedge clk); #1;
    check_val("abort_gnt", a_gnt, 1'b1);
    @(negedge clk); scramble(0);
    @(posedge clk); #1;
    check_val("abort_in_wait", {busy, mem_clken, mem_chipselect}, 3'b110);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    reset_checks("abort");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_idle", {busy, a_done, b_done}, 3'b000);
    @(negedge clk);
    set_req(1, 1'b0, 7'h10, 32'h0, 4'h0);        issue(1'b0, w);
    check_val("post_rst_win", w, 1);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? a_req : b_req) == 1'b0 && $urandom_range(0, 1) == 1)
          set_req(p, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 15)),
                  $urandom, 4'($urandom));
      end
      if (a_req || b_req) begin
        issue($urandom_range(0, 3) == 0, w);
      end else begin
        @(posedge clk); #1;
        check_val("idle_quiet", {busy, a_gnt, b_gnt, mem_clken}, 4'b0000);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_s2_arbiter.md
MEM_S2_ARBITER -- requirements
Module: mem_s2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, word address width of the shared on-chip RAM s2 port.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports a_req, a_we  in  1 each  requester A (SPI bridge): access request, 1 = write.
REQ-006 SHALL have ports a_addr  in  ADDR_W; a_wdata  in  DATA_W; a_be  in  DATA_W/8  requester A access fields.
REQ-007 SHALL have ports a_gnt, a_done  out  1 each; a_rdata  out  DATA_W  requester A grant pulse, completion pulse, read data.
REQ-008 SHALL have the same seven ports with prefix b_ for requester B (Nios-side data PIO bridge).
REQ-009 SHALL have ports mem_address  out  ADDR_W; mem_chipselect, mem_clken, mem_write  out  1 each; mem_writedata  out  DATA_W; mem_byteenable  out  DATA_W/8; mem_readdata  in  DATA_W  s2 port of the shared RAM, read latency 1.
REQ-010 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-012 IDLE: if any req is high, SHALL select a winner, latch its we/addr/wdata/be, and go to ACCESS; otherwise stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: if both req are high, the requester not served last wins; a single requester always wins.
REQ-014 ACCESS: SHALL drive mem_chipselect=1, mem_clken=1, mem_write=latched we, and the latched address, data and byte-enable, all from registers; the winner's gnt SHALL pulse high for exactly this cycle.
REQ-015 WAIT: mem_chipselect and mem_write SHALL be 0 and mem_clken SHALL be 1; on reads, mem_readdata SHALL be captured into the winner's rdata register at the end of this cycle.
REQ-016 RESP: the winner's done SHALL pulse high for one cycle; for reads, rdata SHALL be valid in the same cycle.
REQ-017 rdata SHALL hold its value until the next read completes for that requester; writes SHALL leave rdata unchanged.
REQ-018 Latency SHALL be: req sampled in IDLE at cycle N, gnt at N+1, done at N+3; maximum throughput is one access per 4 cycles.
REQ-019 Requesters SHALL hold req and all fields stable until gnt; after gnt they may drop or change them with no effect on the current access.
REQ-020 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-021 A write with be=0 SHALL still run the full sequence and produce done.
REQ-022 The loser of an arbitration SHALL be served next if it still requests, so neither requester waits more than one other access.
REQ-023 Outside ACCESS, mem_write and mem_chipselect SHALL be 0; mem_clken SHALL be 1 only in ACCESS and WAIT.

Reset
REQ-024 While reset is high, the FSM SHALL go to IDLE and busy, gnt, done, mem_chipselect, mem_clken and mem_write SHALL be 0.
REQ-025 While reset is high, rdata, mem_address, mem_writedata and mem_byteenable SHALL be 0, and the round-robin pointer SHALL favour A.
REQ-026 Reset asserted mid-access SHALL abort the access with no done pulse; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-027 When macro MEM_ARB_FIXED_PRIO_EN is defined, A SHALL always win simultaneous requests, and the round-robin pointer SHALL not be implemented.
REQ-028 When MEM_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-013 SHALL apply.

Verification
REQ-029 A write, then a read: a_req with we=1, addr=0x05, wdata=0xDEADBEEF, be=0xF -> a_gnt at +1, mem_write=1 at addr 0x05, a_done at +3; A read of 0x05 -> a_rdata=0xDEADBEEF with a_done.
REQ-030 Byte-enable: write 0x11223344 with be=0x3 over 0xFFFFFFFF -> B read returns 0xFFFF3344.
REQ-031 Contention: a_req and b_req held together from reset for 4 accesses -> grant order A,B,A,B, with gnt pulses 4 cycles apart; with MEM_ARB_FIXED_PRIO_EN the order is A,A,A,A while a_req is held.
REQ-032 Reset in WAIT of a read: reset high for 1 cycle -> no done, busy=0, and the next request is granted normally 1 cycle after sampling.
REQ-033 Zero byte-enable: write with be=0 to addr 0x7F -> done pulses and memory at 0x7F is unchanged on readback.
